// File: rtl/flag_branch_unit_pkg.sv
// Shared encodings for the flag/branch unit: condition codes, flag bit
// positions and the sequencing FSM state type.
package flag_branch_pkg;

  localparam int BR_CW = 3;

  localparam logic [BR_CW-1:0] BR_B    = 3'b000;
  localparam logic [BR_CW-1:0] BR_BLTZ = 3'b001;
  localparam logic [BR_CW-1:0] BR_BZ   = 3'b010;
  localparam logic [BR_CW-1:0] BR_BNZ  = 3'b011;
  localparam logic [BR_CW-1:0] BR_BL   = 3'b100;
  localparam logic [BR_CW-1:0] BR_BCY  = 3'b101;
  localparam logic [BR_CW-1:0] BR_BNCY = 3'b110;
  localparam logic [BR_CW-1:0] BR_RET  = 3'b111;

  localparam int FLG_C = 3;
  localparam int FLG_S = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [3:0] pack_flags(input logic c, input logic s,
                                            input logic v, input logic z);
    return {c, s, v, z};
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// ALU-status / branch / fetch bundle between the pipeline and the flag_branch_unit.
interface flag_branch_unit_if #(
  parameter int SIZE     = 32,
  parameter int BR_CSIZE = 3
);
  logic                alu_valid;
  logic                flags_we;
  logic                carryflag;
  logic                signflag;
  logic                overflowflag;
  logic                zflag;
  logic                stall;
  logic                br_valid;
  logic [BR_CSIZE-1:0] br_cond;
  logic [SIZE-1:0]     br_target;
  logic [SIZE-1:0]     pc;
  logic                pc_valid;
  logic [SIZE-1:0]     link;
  logic [3:0]          flags_q;
  logic                br_taken;
  logic                flush;

  modport master (
    output alu_valid, flags_we, carryflag, signflag, overflowflag, zflag,
    output stall, br_valid, br_cond, br_target,
    input  pc, pc_valid, link, flags_q, br_taken, flush
  );

  modport slave (
    input  alu_valid, flags_we, carryflag, signflag, overflowflag, zflag,
    input  stall, br_valid, br_cond, br_target,
    output pc, pc_valid, link, flags_q, br_taken, flush
  );
endinterface

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Combinational branch resolution: condition code against effective flags.
module branch_cond_eval
  import flag_branch_pkg::*;
(
  input  logic [BR_CW-1:0] i_cond,
  input  logic             i_carry,
  input  logic             i_sign,
  input  logic             i_zero,
  output logic             o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      BR_B, BR_BL, BR_RET: o_taken = 1'b1;
      BR_BLTZ:             o_taken = i_sign;
      BR_BZ:               o_taken = i_zero;
      BR_BNZ:              o_taken = ~i_zero;
      BR_BCY:              o_taken = i_carry;
      BR_BNCY:             o_taken = ~i_carry;
      default:             o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register, PC/link ownership and branch redirect FSM
// sitting between the ALU and instruction fetch.
module flag_branch_unit
  import flag_branch_pkg::*;
#(
  parameter int              SIZE      = 32,
  parameter int              BR_CSIZE  = 3,
  parameter logic [SIZE-1:0] RESET_VEC = '0
) (
  input logic              clk,
  input logic              rst,
  flag_branch_unit_if.slave bus
);

  localparam logic [SIZE-1:0] ALIGN_MASK = {{(SIZE-2){1'b1}}, 2'b00};

  state_t          r_state;
  logic [SIZE-1:0] r_pc;
  logic            r_pc_valid;
  logic [SIZE-1:0] r_link;
  logic [3:0]      r_flags;
  logic            r_br_taken;
  logic            r_flush;

  logic [3:0]      w_alu_flags;
  logic            w_flag_wr;
  logic [3:0]      w_eff_flags;
  logic            w_taken;
  logic            w_redirect;
  logic [SIZE-1:0] w_pc_plus4;
  logic [SIZE-1:0] w_target;

  assign w_alu_flags = pack_flags(bus.carryflag, bus.signflag, bus.overflowflag, bus.zflag);
  assign w_flag_wr   = bus.alu_valid & bus.flags_we;
  // Same-cycle ALU flags bypass the register so a compare+branch pair resolves correctly.
  assign w_eff_flags = w_flag_wr ? w_alu_flags : r_flags;
  assign w_pc_plus4  = r_pc + SIZE'(4);
  assign w_target    = (bus.br_cond == BR_RET) ? r_link : (bus.br_target & ALIGN_MASK);
  assign w_redirect  = (r_state == ST_RUN) & bus.br_valid & ~bus.stall & w_taken;

  branch_cond_eval u_cond (
    .i_cond  (bus.br_cond),
    .i_carry (w_eff_flags[FLG_C]),
    .i_sign  (w_eff_flags[FLG_S]),
    .i_zero  (w_eff_flags[FLG_Z]),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_flag_wr && !bus.stall) begin
      r_flags <= w_alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RESET;
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b0;
      r_link     <= '0;
      r_br_taken <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
          r_br_taken <= 1'b0;
          r_flush    <= 1'b0;
        end
        ST_RUN: begin
          if (!bus.stall) begin
            if (w_redirect) begin
              r_pc       <= w_target;
              r_br_taken <= 1'b1;
              r_flush    <= 1'b1;
              r_state    <= ST_FLUSH;
              if (bus.br_cond == BR_BL) r_link <= w_pc_plus4 & ALIGN_MASK;
            end else begin
              r_pc       <= w_pc_plus4;
              r_br_taken <= 1'b0;
              r_flush    <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          // Anything on br_valid here is wrong-path and is dropped.
          if (!bus.stall) begin
            r_pc       <= w_pc_plus4;
            r_br_taken <= 1'b0;
            r_flush    <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        default: begin
          r_state    <= ST_RESET;
          r_pc       <= RESET_VEC;
          r_pc_valid <= 1'b0;
          r_br_taken <= 1'b0;
          r_flush    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_valid = r_pc_valid;
  assign bus.link     = r_link;
  assign bus.flags_q  = r_flags;
  assign bus.br_taken = r_br_taken;
  assign bus.flush    = r_flush;

endmodule
